ascon_axil_regfile: RTL

Parametrised AXI4-Lite slave register file for the Ascon AEAD128 IP, the next generation of the fixed 26-register AXI front end. It supports full read and write channels, byte strobes, a per-register read-only mask fed live from the cipher core, and SLVERR on bad addresses. It sits between the SoC AXI4-Lite interconnect and the ascon_aead128 core: control, key, nonce and data registers go to the core, and status and tag registers come from it.

---
 rtl/ascon_axil_regfile_if.sv | 50 +++++
 rtl/ascon_axil_regfile.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_axil_regfile_if.sv
// ----------------------------------------------------------------------------
// ascon_axil_regfile_if
//
// AXI4-Lite bundle between the SoC interconnect (master) and the Ascon
// register file (slave). The widths follow the register file's parameters.
//
// Handshake rule for every channel: a beat transfers on a rising clock edge
// where both VALID and READY are high. A source that has raised VALID holds
// it and the payload steady until that edge. READY may be raised or lowered
// at any time.
//
// Channels:
//   AR : araddr, arvalid (master) / arready (slave)
//   R  : rdata, rresp, rvalid (slave) / rready (master)
//   AW : awaddr, awvalid (master) / awready (slave)
//   W  : wdata, wstrb, wvalid (master) / wready (slave)
//   B  : bresp, bvalid (slave) / bready (master)
// ----------------------------------------------------------------------------
interface ascon_axil_regfile_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32
);
    logic [ADDRESS_WIDTH-1:0]  araddr;
    logic                      arvalid;
    logic                      arready;
    logic [DATA_WIDTH-1:0]     rdata;
    logic [1:0]                rresp;
    logic                      rvalid;
    logic                      rready;
    logic [ADDRESS_WIDTH-1:0]  awaddr;
    logic                      awvalid;
    logic                      awready;
    logic [DATA_WIDTH-1:0]     wdata;
    logic [DATA_WIDTH/8-1:0]   wstrb;
    logic                      wvalid;
    logic                      wready;
    logic [1:0]                bresp;
    logic                      bvalid;
    logic                      bready;

    modport master (
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/ascon_axil_regfile.sv
// ----------------------------------------------------------------------------
// ascon_axil_regfile
//
// AXI4-Lite slave register file for the Ascon AEAD128 core. It holds NB_REG
// registers of DATA_WIDTH bits starting at byte address BASE_ADDR. Registers
// flagged in RO_MASK are read live from the core (reg_in_i) and reject
// writes with SLVERR. Out-of-range or misaligned addresses also answer
// SLVERR. The read and write paths are independent FSMs, so one read and
// one write can be in flight at the same time.
//
// Ports:
//   aclk_i      clock, single domain
//   areset_i    synchronous active-high reset
//   s_axil      AXI4-Lite slave bundle (AR, R, AW, W, B channels)
//   reg_out_o   flat register image, register i at [i*DATA_WIDTH +: DATA_WIDTH]
//   reg_in_i    core values for the read-only registers
//   wr_pulse_o  one-cycle strobe per register after each accepted write
//   rd_pulse_o  one-cycle strobe per register after each completed read
//   rd_state_o  read FSM state (debug)
//   wr_state_o  write FSM state (debug)
// ----------------------------------------------------------------------------
module ascon_axil_regfile #(
    parameter int                       DATA_WIDTH    = 32,
    parameter int                       ADDRESS_WIDTH = 32,
    parameter int                       NB_REG        = 26,
    // ASCON_AEAD128_BASE_ADDR in the SoC address map.
    parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR     = ADDRESS_WIDTH'(32'h4000_0000),
    parameter logic [NB_REG-1:0]        RO_MASK       = '0
) (
    input  logic                         aclk_i,
    input  logic                         areset_i,
    ascon_axil_regfile_if.slave          s_axil,
    output logic [NB_REG*DATA_WIDTH-1:0] reg_out_o,
    input  logic [NB_REG*DATA_WIDTH-1:0] reg_in_i,
    output logic [NB_REG-1:0]            wr_pulse_o,
    output logic [NB_REG-1:0]            rd_pulse_o,
    output logic                         rd_state_o,
    output logic [1:0]                   wr_state_o
);

    localparam int STRB_W   = DATA_WIDTH / 8;
    localparam int ADDR_LSB = (STRB_W > 1) ? $clog2(STRB_W) : 0;
    localparam int IDX_W    = (NB_REG > 1) ? $clog2(NB_REG) : 1;

    // Offset bits below the register granule; any of them set is misaligned.
    localparam logic [ADDRESS_WIDTH-1:0] LSB_MASK = ADDRESS_WIDTH'((1 << ADDR_LSB) - 1);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_ADDR,
        W_HAVE_DATA,
        W_RESP
    } wr_state_t;

    // ------------------------------------------------------------------
    // Address decode, shared by the read and write paths.
    // The subtraction wraps at ADDRESS_WIDTH, so the explicit addr >= base
    // test is what rejects addresses below the window.
    // ------------------------------------------------------------------
    function automatic logic decode_ok(input logic [ADDRESS_WIDTH-1:0] addr);
        logic [ADDRESS_WIDTH-1:0] off;
        off = addr - BASE_ADDR;
        return (addr >= BASE_ADDR) &&
               ((off & LSB_MASK) == '0) &&
               ((off >> ADDR_LSB) < ADDRESS_WIDTH'(NB_REG));
    endfunction

    function automatic logic [IDX_W-1:0] decode_idx(input logic [ADDRESS_WIDTH-1:0] addr);
        return IDX_W'((addr - BASE_ADDR) >> ADDR_LSB);
    endfunction

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] regs_q [NB_REG];

    for (genvar g = 0; g < NB_REG; g++) begin : g_reg_out
        assign reg_out_o[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    rd_state_t             rd_state_q;
    logic                  arready_q;
    logic                  rvalid_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            rresp_q;
    logic                  rd_ok_q;
    logic [IDX_W-1:0]      rd_idx_q;
    logic [NB_REG-1:0]     rd_pulse_q;

    logic                  ar_ok;
    logic [IDX_W-1:0]      ar_idx;
    logic [DATA_WIDTH-1:0] ar_val;

    // Value returned for the address on the AR channel. regs_q is read
    // before any same-cycle write lands, so a colliding read sees the old
    // contents.
    always_comb begin
        ar_ok  = decode_ok(s_axil.araddr);
        ar_idx = decode_idx(s_axil.araddr);
        ar_val = '0;
        if (ar_ok) begin
            if (RO_MASK[ar_idx]) begin
                ar_val = reg_in_i[ar_idx*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                ar_val = regs_q[ar_idx];
            end
        end
    end

    always_ff @(posedge aclk_i) begin
        if (areset_i) begin
            rd_state_q <= R_IDLE;
            arready_q  <= 1'b1;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
            rd_ok_q    <= 1'b0;
            rd_idx_q   <= '0;
            rd_pulse_q <= '0;
        end else begin
            rd_pulse_q <= '0;
            case (rd_state_q)
                R_IDLE: begin
                    if (s_axil.arvalid) begin
                        rdata_q    <= ar_val;
                        rresp_q    <= ar_ok ? RESP_OKAY : RESP_SLVERR;
                        rd_ok_q    <= ar_ok;
                        rd_idx_q   <= ar_idx;
                        arready_q  <= 1'b0;
                        rvalid_q   <= 1'b1;
                        rd_state_q <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (s_axil.rready) begin
                        // Clear-on-read hook for the core: fires only once
                        // the master has actually taken the data.
                        if (rd_ok_q) begin
                            rd_pulse_q <= NB_REG'(1) << rd_idx_q;
                        end
                        rvalid_q   <= 1'b0;
                        arready_q  <= 1'b1;
                        rd_state_q <= R_IDLE;
                    end
                end
                default: rd_state_q <= R_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
    wr_state_t                wr_state_q;
    logic                     awready_q;
    logic                     wready_q;
    logic                     bvalid_q;
    logic [1:0]               bresp_q;
    logic [NB_REG-1:0]        wr_pulse_q;
    logic [ADDRESS_WIDTH-1:0] aw_addr_q;
    logic [DATA_WIDTH-1:0]    w_data_q;
    logic [STRB_W-1:0]        w_strb_q;

    logic                     cm_fire;
    logic [ADDRESS_WIDTH-1:0] cm_addr;
    logic [DATA_WIDTH-1:0]    cm_data;
    logic [STRB_W-1:0]        cm_strb;
    logic [IDX_W-1:0]         cm_idx;
    logic                     cm_ok;

    // A commit happens in the cycle the second of AW/W arrives; whichever
    // half came earlier is taken from its holding register.
    always_comb begin
        cm_addr = (wr_state_q == W_HAVE_ADDR) ? aw_addr_q : s_axil.awaddr;
        cm_data = (wr_state_q == W_HAVE_DATA) ? w_data_q  : s_axil.wdata;
        cm_strb = (wr_state_q == W_HAVE_DATA) ? w_strb_q  : s_axil.wstrb;
        cm_idx  = decode_idx(cm_addr);
        cm_ok   = decode_ok(cm_addr) && !RO_MASK[cm_idx];
        case (wr_state_q)
            W_IDLE:      cm_fire = s_axil.awvalid && s_axil.wvalid;
            W_HAVE_ADDR: cm_fire = s_axil.wvalid;
            W_HAVE_DATA: cm_fire = s_axil.awvalid;
            default:     cm_fire = 1'b0;
        endcase
    end

    always_ff @(posedge aclk_i) begin
        if (areset_i) begin
            wr_state_q <= W_IDLE;
            awready_q  <= 1'b1;
            wready_q   <= 1'b1;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            wr_pulse_q <= '0;
            aw_addr_q  <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            for (int i = 0; i < NB_REG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            wr_pulse_q <= '0;
            if (cm_fire) begin
                if (cm_ok) begin
                    for (int b = 0; b < STRB_W; b++) begin
                        if (cm_strb[b]) begin
                            regs_q[cm_idx][8*b +: 8] <= cm_data[8*b +: 8];
                        end
                    end
                    // Pulses even with an all-zero strobe: the core may use
                    // the write itself as a command.
                    wr_pulse_q <= NB_REG'(1) << cm_idx;
                    bresp_q    <= RESP_OKAY;
                end else begin
                    bresp_q    <= RESP_SLVERR;
                end
                bvalid_q   <= 1'b1;
                awready_q  <= 1'b0;
                wready_q   <= 1'b0;
                wr_state_q <= W_RESP;
            end else begin
                case (wr_state_q)
                    W_IDLE: begin
                        if (s_axil.awvalid) begin
                            aw_addr_q  <= s_axil.awaddr;
                            awready_q  <= 1'b0;
                            wr_state_q <= W_HAVE_ADDR;
                        end else if (s_axil.wvalid) begin
                            w_data_q   <= s_axil.wdata;
                            w_strb_q   <= s_axil.wstrb;
                            wready_q   <= 1'b0;
                            wr_state_q <= W_HAVE_DATA;
                        end
                    end
                    W_HAVE_ADDR: ;
                    W_HAVE_DATA: ;
                    W_RESP: begin
                        if (s_axil.bready) begin
                            bvalid_q   <= 1'b0;
                            awready_q  <= 1'b1;
                            wready_q   <= 1'b1;
                            wr_state_q <= W_IDLE;
                        end
                    end
                    default: wr_state_q <= W_IDLE;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign s_axil.arready = arready_q;
    assign s_axil.rvalid  = rvalid_q;
    assign s_axil.rdata   = rdata_q;
    assign s_axil.rresp   = rresp_q;
    assign s_axil.awready = awready_q;
    assign s_axil.wready  = wready_q;
    assign s_axil.bvalid  = bvalid_q;
    assign s_axil.bresp   = bresp_q;

    assign wr_pulse_o = wr_pulse_q;
    assign rd_pulse_o = rd_pulse_q;
    assign rd_state_o = rd_state_q;
    assign wr_state_o = wr_state_q;

endmodule
